fsm_enchimento_multi: RTL and testbench
=======================================

// Module: fsm_enchimento_multi
// PURPOSE
//   N-channel Moore controller for the filling valves of a multi-head filler.
//   Each channel takes a start command from the master FSM and drives its valve
//   until its level sensor reads full, then reports completion.
//   Adds per-channel sensor synchronisation and debounce, global abort, and an
//   optional fill watchdog with a fault state.
//   Sits between the master sequencer and the LEDR valve outputs and SW level inputs.
// PARAMETERS
//   N_CANAIS      4        number of filling heads/channels (>=1)
//   DEBOUNCE_CYC  16       cycles sensor must differ from filtered value to flip it (>=1)
//   TIMEOUT_CYC   1000000  max cycles in ENCHENDO before FALHA (FILL_TIMEOUT_EN only, >=2)
// PORTS
//   clk               in   1         system clock, 50 MHz
//   reset             in   1         reset, asynchronous, active-high
//   cmd_iniciar       in   N_CANAIS  per-channel start command from master (level)
//   sensor_nivel      in   N_CANAIS  per-channel level sensor, 1 = full (async)
//   abortar           in   1         global abort, synchronous, level
//   valvula_ativa     out  N_CANAIS  valve open; 1 only in ENCHENDO
//   tarefa_concluida  out  N_CANAIS  1 only in CONCLUIDO
//   falha             out  N_CANAIS  1 only in FALHA
//   ocupado           out  1         OR of valvula_ativa
//   qualquer_falha    out  1         OR of falha
// BEHAVIOUR
//   - Reset: all states IDLE; sync FFs, filtered sensor, debounce and timeout counters 0;
//     every output 0. Reset mid-fill closes the valve immediately (async).
//   - Outputs are pure decodes of the registered state; no input-to-output path.
//   - Sensor path per channel: 2-FF synchroniser -> debounce. The debounce counter
//     counts while sync != filtered and clears when they are equal. On reaching
//     DEBOUNCE_CYC-1 with a mismatch, filtered flips and the counter clears.
//     A stable change reaches filtered DEBOUNCE_CYC+2 edges after it is first
//     sampled. Glitches shorter than DEBOUNCE_CYC cycles are ignored.
//   - States: IDLE=00, ENCHENDO=01, CONCLUIDO=10, FALHA=11. Next-state priority:
//     IDLE:      cmd & !filt -> ENCHENDO; cmd & filt -> CONCLUIDO (already full, valve never opens)
//     ENCHENDO:  abortar -> IDLE; else !cmd -> IDLE; else filt -> CONCLUIDO;
//                else timeout -> FALHA; else stay
//     CONCLUIDO: !cmd -> IDLE (abortar also -> IDLE)
//     FALHA:     !cmd -> IDLE (master acknowledges by dropping cmd); abortar has no effect
//   - abortar in IDLE blocks the IDLE->ENCHENDO/CONCLUIDO transitions while high.
//   - If filt and timeout hit on the same cycle, CONCLUIDO wins.
//   - Channels are fully independent; any mix of states is legal.
// CONFIGURATION
//   FILL_TIMEOUT_EN defined: per-channel counter of width $clog2(TIMEOUT_CYC).
//     It clears outside ENCHENDO and counts in ENCHENDO. The timeout condition is
//     count == TIMEOUT_CYC-1, so the valve is open for exactly TIMEOUT_CYC cycles
//     and FALHA is entered on the next edge.
//   FILL_TIMEOUT_EN undefined: no counter, timeout is constant 0, FALHA is
//     unreachable, and falha / qualquer_falha are tied 0.
// STRUCTURE
//   enchimento_pkg: state typedef enum logic[1:0] with the encodings above, and
//     width helper functions (cnt_w via $clog2).
//   Sub-module canal_enchimento: one channel (sync + debounce + FSM + optional
//     timer). The top instantiates N_CANAIS copies in a generate loop and builds
//     the OR reductions.
// TESTING (N_CANAIS=4, DEBOUNCE_CYC=4, TIMEOUT_CYC=20)
//   - Fill: cmd[0]=1, sensor[0]=0 -> valvula[0]=1 one edge later. sensor[0]=1 held
//     -> valvula[0]=0 and concluida[0]=1 exactly 7 edges after first high sample.
//     cmd[0]=0 -> IDLE, all outputs 0.
//   - Glitch: in ENCHENDO, sensor[1] high for 3 cycles -> stays ENCHENDO.
//     High for 4+ cycles -> CONCLUIDO.
//   - Pre-full: sensor[2]=1 settled, then cmd[2]=1 -> concluida[2]=1 and valvula[2]
//     never asserts.
//   - Timeout (FILL_TIMEOUT_EN): cmd[3]=1, sensor low -> valvula[3] high exactly
//     20 cycles, then falha[3]=1 and qualquer_falha=1. cmd[3]=0 -> IDLE.
//     Without the macro: valve stays open indefinitely and falha is always 0.
//   - Abort/reset: all 4 channels filling, abortar=1 -> all IDLE next edge, ocupado=0.
//     Async reset mid-fill -> outputs 0 before the next edge.
//   - Simultaneous: filtered sensor rises on the timeout cycle -> CONCLUIDO, not FALHA.

Source files
------------

// File: rtl/enchimento_pkg.sv
// Shared types and width helpers for the multi-head filling-valve controller.
// State encodings match the master sequencer's status decode.
package enchimento_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ENCHENDO  = 2'b01,
    CONCLUIDO = 2'b10,
    FALHA     = 2'b11
  } estado_t;

  // Bits needed for a counter that must hold values 0..n-1 (never narrower than 1).
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/canal_enchimento.sv
// One filling head: sensor synchroniser + debounce, valve FSM, optional fill watchdog.
// Watchdog and FALHA state exist only when FILL_TIMEOUT_EN is defined.
module canal_enchimento
  import enchimento_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16,
  parameter int TIMEOUT_CYC  = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic cmd_iniciar_i,
  input  logic sensor_nivel_i,
  input  logic abortar_i,
  output logic valvula_ativa_o,
  output logic tarefa_concluida_o,
  output logic falha_o
);

  localparam int             DB_W   = cnt_w(DEBOUNCE_CYC);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYC - 1);

  logic            sync1_q, sync2_q, filt_q;
  logic [DB_W-1:0] dbCnt_q;
  estado_t         estado_q, estado_d;
  logic            valvula_q, concluida_q, falha_q;
  logic            timeout;

  // A new level must disagree with the filtered value for DEBOUNCE_CYC cycles in a row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      dbCnt_q <= '0;
    end else begin
      sync1_q <= sensor_nivel_i;
      sync2_q <= sync1_q;
      if (sync2_q == filt_q) begin
        dbCnt_q <= '0;
      end else if (dbCnt_q == DB_MAX) begin
        filt_q  <= ~filt_q;
        dbCnt_q <= '0;
      end else begin
        dbCnt_q <= dbCnt_q + 1'b1;
      end
    end
  end

`ifdef FILL_TIMEOUT_EN
  localparam bit               TIMEOUT_ON = 1'b1;
  localparam int               TMR_W      = cnt_w(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_MAX    = TMR_W'(TIMEOUT_CYC - 1);

  logic [TMR_W-1:0] tmr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr_q <= '0;
    end else if (estado_q == ENCHENDO) begin
      tmr_q <= tmr_q + 1'b1;
    end else begin
      tmr_q <= '0;
    end
  end

  assign timeout = (estado_q == ENCHENDO) && (tmr_q == TMR_MAX);
`else
  localparam bit TIMEOUT_ON = 1'b0;
  assign timeout = 1'b0;
`endif

  // Abort wins over everything except an unacknowledged fault.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      IDLE: begin
        if (cmd_iniciar_i && !abortar_i) begin
          estado_d = filt_q ? CONCLUIDO : ENCHENDO;
        end
      end
      ENCHENDO: begin
        if (abortar_i || !cmd_iniciar_i) begin
          estado_d = IDLE;
        end else if (filt_q) begin
          estado_d = CONCLUIDO;
        end else if (timeout) begin
          estado_d = FALHA;
        end
      end
      CONCLUIDO: begin
        if (!cmd_iniciar_i || abortar_i) begin
          estado_d = IDLE;
        end
      end
      FALHA: begin
        if (!cmd_iniciar_i) begin
          estado_d = IDLE;
        end
      end
      default: estado_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q    <= IDLE;
      valvula_q   <= 1'b0;
      concluida_q <= 1'b0;
      falha_q     <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      valvula_q   <= (estado_d == ENCHENDO);
      concluida_q <= (estado_d == CONCLUIDO);
      falha_q     <= (estado_d == FALHA) && TIMEOUT_ON;
    end
  end

  assign valvula_ativa_o    = valvula_q;
  assign tarefa_concluida_o = concluida_q;
  assign falha_o            = falha_q;

endmodule

// File: rtl/fsm_enchimento_multi.sv
// N-channel filling-valve controller: independent channels plus busy/fault summaries.
// Define FILL_TIMEOUT_EN to enable the per-channel fill watchdog and FALHA state.
module fsm_enchimento_multi
  import enchimento_pkg::*;
#(
  parameter int N_CANAIS     = 4,
  parameter int DEBOUNCE_CYC = 16,
  parameter int TIMEOUT_CYC  = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_CANAIS-1:0] cmd_iniciar_i,
  input  logic [N_CANAIS-1:0] sensor_nivel_i,
  input  logic                abortar_i,
  output logic [N_CANAIS-1:0] valvula_ativa_o,
  output logic [N_CANAIS-1:0] tarefa_concluida_o,
  output logic [N_CANAIS-1:0] falha_o,
  output logic                ocupado_o,
  output logic                qualquer_falha_o
);

  for (genvar ch = 0; ch < N_CANAIS; ch++) begin : gCanal
    canal_enchimento #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .TIMEOUT_CYC  (TIMEOUT_CYC)
    ) uCanal (
      .clk                (clk),
      .reset              (reset),
      .cmd_iniciar_i      (cmd_iniciar_i[ch]),
      .sensor_nivel_i     (sensor_nivel_i[ch]),
      .abortar_i          (abortar_i),
      .valvula_ativa_o    (valvula_ativa_o[ch]),
      .tarefa_concluida_o (tarefa_concluida_o[ch]),
      .falha_o            (falha_o[ch])
    );
  end

  assign ocupado_o        = |valvula_ativa_o;
  assign qualquer_falha_o = |falha_o;

endmodule

// File: tb/tb_fsm_enchimento_multi.sv
// Self-checking bench for fsm_enchimento_multi: behavioural model compared every cycle
// plus directed literal checks. Works with or without FILL_TIMEOUT_EN.
module tb_fsm_enchimento_multi;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int TC = 20;
`ifdef FILL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_FILL  = 1;
  localparam int M_DONE  = 2;
  localparam int M_FAULT = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] cmd, sensor;
  logic         abortar;
  logic [N-1:0] valvula, concluida, falha;
  logic         ocupado, qfalha;

  int checks = 0;
  int errors = 0;
  bit cmpEn  = 1'b0;

  always #5 clk = ~clk;

  fsm_enchimento_multi #(
    .N_CANAIS     (N),
    .DEBOUNCE_CYC (D),
    .TIMEOUT_CYC  (TC)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .cmd_iniciar_i      (cmd),
    .sensor_nivel_i     (sensor),
    .abortar_i          (abortar),
    .valvula_ativa_o    (valvula),
    .tarefa_concluida_o (concluida),
    .falha_o            (falha),
    .ocupado_o          (ocupado),
    .qualquer_falha_o   (qfalha)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] c, input logic [N-1:0] s, input logic a);
    cmd     = c;
    sensor  = s;
    abortar = a;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Behavioural model: sensor seen two edges late, accepted after D consecutive disagreeing samples.
  int mMode[N];
  int mRun[N];
  int mOpen[N];
  bit mFilt[N];
  bit mPipe0[N];
  bit mPipe1[N];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int ch = 0; ch < N; ch++) begin
        mMode[ch] = M_IDLE; mRun[ch] = 0; mOpen[ch] = 0;
        mFilt[ch] = 1'b0; mPipe0[ch] = 1'b0; mPipe1[ch] = 1'b0;
      end
    end else begin
      for (int ch = 0; ch < N; ch++) begin
        case (mMode[ch])
          M_IDLE:
            if (cmd[ch] && !abortar) begin
              mMode[ch] = mFilt[ch] ? M_DONE : M_FILL;
              mOpen[ch] = 0;
            end
          M_FILL: begin
            mOpen[ch]++;
            if (abortar || !cmd[ch])           mMode[ch] = M_IDLE;
            else if (mFilt[ch])                mMode[ch] = M_DONE;
            else if (TMO_EN && mOpen[ch] >= TC) mMode[ch] = M_FAULT;
          end
          M_DONE:  if (!cmd[ch] || abortar) mMode[ch] = M_IDLE;
          default: if (!cmd[ch]) mMode[ch] = M_IDLE;
        endcase
        if (mPipe1[ch] != mFilt[ch]) begin
          mRun[ch]++;
          if (mRun[ch] == D) begin
            mFilt[ch] = ~mFilt[ch];
            mRun[ch]  = 0;
          end
        end else begin
          mRun[ch] = 0;
        end
        mPipe1[ch] = mPipe0[ch];
        mPipe0[ch] = sensor[ch];
      end
    end
  end

  always @(negedge clk) begin
    if (cmpEn && !reset) begin
      logic [N-1:0] eV, eC, eF;
      eV = '0; eC = '0; eF = '0;
      for (int ch = 0; ch < N; ch++) begin
        eV[ch] = (mMode[ch] == M_FILL);
        eC[ch] = (mMode[ch] == M_DONE);
        eF[ch] = (mMode[ch] == M_FAULT);
      end
      checkOutput("model_valvula", valvula, eV);
      checkOutput("model_concluida", concluida, eC);
      checkOutput("model_falha", falha, eF);
      checkOutput("model_ocupado", ocupado, |eV);
      checkOutput("model_qfalha", qfalha, |eF);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int openCnt;
    applyStimulus('0, '0, 1'b0);
    reset = 1'b1;
    step(2);
    checkOutput("reset_valvula", valvula, 0);
    checkOutput("reset_concluida", concluida, 0);
    checkOutput("reset_falha", falha, 0);
    checkOutput("reset_flags", {ocupado, qfalha}, 0);
    reset = 1'b0;
    cmpEn = 1'b1;

    // Fill on channel 0: sensor high first sampled at E1, done at E7
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    step(1);
    checkOutput("fill_open", valvula[0], 1);
    applyStimulus(4'b0001, 4'b0001, 1'b0);
    step(6);
    checkOutput("fill_still_open_e6", valvula[0], 1);
    step(1);
    checkOutput("fill_done_e7", concluida[0], 1);
    checkOutput("fill_valve_closed_e7", valvula[0], 0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    step(1);
    checkOutput("fill_release", {valvula, concluida, falha}, 0);
    step(8);

    // Glitch on channel 1: 3 high cycles ignored, 4 accepted
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    step(1);
    applyStimulus(4'b0010, 4'b0010, 1'b0);
    step(3);
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    step(8);
    checkOutput("glitch_still_filling", valvula[1], 1);
    checkOutput("glitch_not_done", concluida[1], 0);
    applyStimulus(4'b0010, 4'b0010, 1'b0);
    step(4);
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    step(3);
    checkOutput("glitch4_done", concluida[1], 1);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    step(8);

    // Pre-full channel 2, then abort while done
    applyStimulus(4'b0000, 4'b0100, 1'b0);
    step(8);
    applyStimulus(4'b0100, 4'b0100, 1'b0);
    step(1);
    checkOutput("prefull_done", concluida[2], 1);
    checkOutput("prefull_valve_shut", valvula[2], 0);
    applyStimulus(4'b0100, 4'b0100, 1'b1);
    step(1);
    checkOutput("abort_from_done", concluida[2], 0);
    applyStimulus(4'b0100, 4'b0100, 1'b0);
    step(1);
    checkOutput("prefull_done_again", concluida[2], 1);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    step(8);

    // Timeout on channel 3 (bounded loop)
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    openCnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (valvula[3]) openCnt++;
      else break;
    end
    checkOutput("timeout_open_cycles", openCnt, TMO_EN ? TC : 40);
    checkOutput("timeout_falha", falha[3], TMO_EN);
    checkOutput("timeout_qfalha", qfalha, TMO_EN);
    applyStimulus(4'b1000, 4'b0000, 1'b1);
    step(2);
    checkOutput("fault_ignores_abort", falha[3], TMO_EN);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    step(1);
    checkOutput("fault_ack", {falha[3], qfalha}, 0);
    step(2);

    // Filtered sensor rises exactly on the timeout edge -> done wins
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    step(1);
    step(13);
    applyStimulus(4'b1000, 4'b1000, 1'b0);
    step(6);
    checkOutput("simul_pre_open", valvula[3], 1);
    step(1);
    checkOutput("simul_done", concluida[3], 1);
    checkOutput("simul_no_fault", falha[3], 0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    step(8);

    // Global abort with all channels filling
    applyStimulus(4'b1111, 4'b0000, 1'b0);
    step(1);
    checkOutput("all_filling", valvula, 4'b1111);
    checkOutput("all_busy", ocupado, 1);
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    step(1);
    checkOutput("abort_all_idle", valvula, 0);
    checkOutput("abort_not_busy", ocupado, 0);
    step(2);
    checkOutput("abort_blocks_start", valvula, 0);
    applyStimulus(4'b1111, 4'b0000, 1'b0);
    step(1);
    checkOutput("refill_after_abort", valvula, 4'b1111);

    // Asynchronous reset mid-fill
    step(3);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_valvula", valvula, 0);
    checkOutput("async_reset_ocupado", ocupado, 0);
    step(2);
    cmpEn = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
